instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetches one- and two-word instructions from a combinational
//               instruction memory, handles redirects, stalls and interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        int_req,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [4:0]  if_opcode,
  output logic [15:0] if_imm,
  output logic [15:0] if_pc,
  output logic [15:0] if_next_pc
);

  localparam logic [1:0] c_RESET_VEC = 2'd0;
  localparam logic [1:0] c_FETCH     = 2'd1;
  localparam logic [1:0] c_IMM       = 2'd2;
  localparam logic [1:0] c_INT_VEC   = 2'd3;

  localparam logic [4:0] c_OP_LDM = 5'h0C;
  localparam logic [4:0] c_OP_LDD = 5'h0D;
  localparam logic [4:0] c_OP_STD = 5'h0E;
  localparam logic [4:0] c_OP_INT = 5'h1E;

  localparam logic [15:0] c_RESET_ADDR = 16'h0000;
  localparam logic [15:0] c_INT_ADDR   = 16'h0001;

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr_hold;
  logic        r_int_pending;
  logic        r_if_valid;
  logic [15:0] r_if_instr;
  logic [15:0] r_if_imm;
  logic [15:0] r_if_pc;
  logic [15:0] r_if_next_pc;

  logic [4:0]  w_fetch_op;
  logic        w_two_word;
  logic        w_take_int;
  logic [15:0] w_pc_inc;
  logic [15:0] w_pc_dec;

  assign w_fetch_op = imem_data[15:11];
  assign w_two_word = (w_fetch_op == c_OP_LDM) || (w_fetch_op == c_OP_LDD) ||
                      (w_fetch_op == c_OP_STD);
  // A same-cycle request counts, so a one-cycle pulse in FETCH is not delayed.
  assign w_take_int = r_int_pending | int_req;
  assign w_pc_inc   = r_pc + 16'd1;
  assign w_pc_dec   = r_pc - 16'd1;

  always_comb begin
    imem_addr = r_pc;
    case (r_state)
      c_RESET_VEC: imem_addr = c_RESET_ADDR;
      c_INT_VEC:   imem_addr = c_INT_ADDR;
      default:     imem_addr = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_RESET_VEC;
      r_pc          <= 16'h0000;
      r_instr_hold  <= 16'h0000;
      r_int_pending <= 1'b0;
      r_if_valid    <= 1'b0;
      r_if_instr    <= 16'h0000;
      r_if_imm      <= 16'h0000;
      r_if_pc       <= 16'h0000;
      r_if_next_pc  <= 16'h0000;
    end else begin
      r_int_pending <= r_int_pending | int_req;
      case (r_state)
        c_RESET_VEC, c_INT_VEC: begin
          r_pc       <= imem_data;
          r_if_valid <= 1'b0;
          r_state    <= c_FETCH;
        end
        c_FETCH: begin
          if (branch_taken) begin
            r_pc       <= branch_target;
            r_if_valid <= 1'b0;
          end else if (stall) begin
            r_state <= c_FETCH;
          end else if (w_take_int) begin
            // pc is left alone so the return address is the next unfetched word
            r_int_pending <= 1'b0;
            r_if_valid    <= 1'b1;
            r_if_instr    <= {c_OP_INT, 11'b0};
            r_if_imm      <= 16'h0000;
            r_if_pc       <= r_pc;
            r_if_next_pc  <= r_pc;
            r_state       <= c_INT_VEC;
          end else if (w_two_word) begin
            r_instr_hold <= imem_data;
            r_pc         <= w_pc_inc;
            r_if_valid   <= 1'b0;
            r_state      <= c_IMM;
          end else begin
            r_if_valid   <= 1'b1;
            r_if_instr   <= imem_data;
            r_if_imm     <= 16'h0000;
            r_if_pc      <= r_pc;
            r_if_next_pc <= w_pc_inc;
            r_pc         <= w_pc_inc;
          end
        end
        c_IMM: begin
          if (branch_taken) begin
            r_pc         <= branch_target;
            r_instr_hold <= 16'h0000;
            r_if_valid   <= 1'b0;
            r_state      <= c_FETCH;
          end else if (stall) begin
            r_state <= c_IMM;
          end else begin
            r_if_valid   <= 1'b1;
            r_if_instr   <= r_instr_hold;
            r_if_imm     <= imem_data;
            r_if_pc      <= w_pc_dec;
            r_if_next_pc <= w_pc_inc;
            r_pc         <= w_pc_inc;
            r_state      <= c_FETCH;
          end
        end
        default: begin
          r_if_valid <= 1'b0;
          r_state    <= c_RESET_VEC;
        end
      endcase
    end
  end

  assign if_valid   = r_if_valid;
  assign if_instr   = r_if_instr;
  assign if_opcode  = r_if_instr[15:11];
  assign if_imm     = r_if_imm;
  assign if_pc      = r_if_pc;
  assign if_next_pc = r_if_next_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam logic [15:0] c_W_ADD1 = 16'h0805;  // opcode 0x01
  localparam logic [15:0] c_W_ADD2 = 16'h0840;
  localparam logic [15:0] c_W_ADD3 = 16'h0900;
  localparam logic [15:0] c_W_ADDF = 16'h0FFF;
  localparam logic [15:0] c_W_LDM1 = 16'h6003;  // opcode 0x0C
  localparam logic [15:0] c_W_LDM2 = 16'h6001;
  localparam logic [15:0] c_W_LDD  = 16'h6800;  // opcode 0x0D
  localparam logic [15:0] c_W_INT  = 16'hF000;  // opcode 0x1E, zero operand

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        int_req;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [4:0]  if_opcode;
  logic [15:0] if_imm;
  logic [15:0] if_pc;
  logic [15:0] if_next_pc;

  logic [15:0] mem [0:65535];
  int          n_cmp;
  int          n_err;

  assign imem_data = mem[imem_addr];

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .int_req       (int_req),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_opcode     (if_opcode),
    .if_imm        (if_imm),
    .if_pc         (if_pc),
    .if_next_pc    (if_next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pkt(input string tag, input logic [15:0] instr, input logic [15:0] imm,
                           input logic [15:0] pc, input logic [15:0] npc);
    check_eq({tag, ".valid"}, {31'b0, if_valid}, 32'd1);
    check_eq({tag, ".instr"}, {16'b0, if_instr}, {16'b0, instr});
    check_eq({tag, ".opcode"}, {27'b0, if_opcode}, {27'b0, instr[15:11]});
    check_eq({tag, ".imm"}, {16'b0, if_imm}, {16'b0, imm});
    check_eq({tag, ".pc"}, {16'b0, if_pc}, {16'b0, pc});
    check_eq({tag, ".next_pc"}, {16'b0, if_next_pc}, {16'b0, npc});
  endtask

  task automatic check_bubble(input string tag, input logic [15:0] addr);
    check_eq({tag, ".valid"}, {31'b0, if_valid}, 32'd0);
    check_eq({tag, ".addr"}, {16'b0, imem_addr}, {16'b0, addr});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h0020;
    mem[16'h0001] = 16'h0100;
    mem[16'h0020] = c_W_ADD1;
    mem[16'h0021] = c_W_LDM1;
    mem[16'h0022] = 16'hBEEF;
    mem[16'h0023] = c_W_LDD;
    mem[16'h0024] = 16'h1234;
    mem[16'h0030] = c_W_LDM2;
    mem[16'h0031] = 16'hCAFE;
    mem[16'h0032] = c_W_ADD1;
    mem[16'h0040] = c_W_ADD2;
    mem[16'h0100] = c_W_ADD3;
    mem[16'hFFFF] = c_W_ADDF;

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000; int_req = 1'b0;
    step();
    step();
    check_eq("rst.valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst.pc", {16'b0, if_pc}, 32'h0);
    check_eq("rst.instr", {16'b0, if_instr}, 32'h0);
    check_eq("rst.next_pc", {16'b0, if_next_pc}, 32'h0);
    check_eq("rst.addr", {16'b0, imem_addr}, 32'h0);

    // Reset vector then first one-word packet on the second edge
    rst = 1'b0;
    step();
    check_bubble("vec", 16'h0020);
    step();
    check_pkt("add", c_W_ADD1, 16'h0000, 16'h0020, 16'h0021);

    // Two-word LDM: bubble then packet with immediate
    step();
    check_bubble("ldm.bub", 16'h0022);
    step();
    check_pkt("ldm", c_W_LDM1, 16'hBEEF, 16'h0021, 16'h0023);

    // LDD first word fetched, redirected during IMM
    step();
    check_bubble("ldd.bub", 16'h0024);
    branch_taken = 1'b1; branch_target = 16'h0040;
    step();
    check_bubble("redir", 16'h0040);
    branch_taken = 1'b0;
    step();
    check_pkt("tgt", c_W_ADD2, 16'h0000, 16'h0040, 16'h0041);

    // Redirect in FETCH to LDM at 0x30, interrupt pulse during its IMM
    branch_taken = 1'b1; branch_target = 16'h0030;
    step();
    check_bubble("br30", 16'h0030);
    branch_taken = 1'b0;
    step();
    check_bubble("ldm2.bub", 16'h0031);
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    check_pkt("ldm2", c_W_LDM2, 16'hCAFE, 16'h0030, 16'h0032);
    step();
    check_pkt("int", c_W_INT, 16'h0000, 16'h0032, 16'h0032);
    check_eq("int.addr", {16'b0, imem_addr}, 32'h0001);
    step();
    check_bubble("intvec", 16'h0100);
    step();
    check_pkt("isr", c_W_ADD3, 16'h0000, 16'h0100, 16'h0101);

    // Redirect to 0xFFFF, stall three cycles, then wrap
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    step();
    check_bubble("brff", 16'hFFFF);
    branch_taken = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_bubble("stall", 16'hFFFF);
      check_eq("stall.pc", {16'b0, if_pc}, 32'h0100);
    end
    stall = 1'b0;
    step();
    check_pkt("wrap", c_W_ADDF, 16'h0000, 16'hFFFF, 16'h0000);
    stall = 1'b1;
    step();
    check_pkt("held", c_W_ADDF, 16'h0000, 16'hFFFF, 16'h0000);
    check_eq("held.addr", {16'b0, imem_addr}, 32'h0000);
    stall = 1'b0;
    step();
    check_pkt("zero", 16'h0020, 16'h0000, 16'h0000, 16'h0001);

    // Reset while in IMM abandons the packet
    branch_taken = 1'b1; branch_target = 16'h0021;
    step();
    branch_taken = 1'b0;
    step();
    check_bubble("ldm3.bub", 16'h0022);
    rst = 1'b1;
    step();
    check_bubble("midrst", 16'h0000);
    check_eq("midrst.pc", {16'b0, if_pc}, 32'h0);
    rst = 1'b0;
    step();
    check_bubble("vec2", 16'h0020);
    step();
    check_pkt("add2", c_W_ADD1, 16'h0000, 16'h0020, 16'h0021);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
